aeolus_sequencer: RTL and testbench
===================================

# aeolus_sequencer

Multi-cycle control sequencer for the Aeolus 8-bit CPU datapath. It steps each instruction through fetch, decode, execute and an optional memory phase, and drives every datapath strobe: PC, IR, ALU, accumulator, flags, output latch and memory bus. It takes the 4-bit opcode from the instruction register, the zero and carry flags, and a ready handshake from the program/data memory. It sits between that memory and the datapath inside AeolusCPUTop.

## Interface
- `IDLE_CYCLES`, default 1: cycles spent in IDLE after reset release before the first FETCH (range 1–15).
- `boardCLK`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE.
- `opcode`  in  4  IR[7:4]; sampled in DECODE and EXECUTE.
- `zeroFlag`, `carryFlag`  in  1 each  datapath flags; sampled in EXECUTE.
- `memReady`  in  1  memory completion for the current request.
- `memRead`, `memWrite`  out  1 each  memory request strobes.
- `addrSel`  out  1  memory address source: 0 = PC, 1 = IR operand.
- `irLoad`, `pcInc`, `pcLoad`  out  1 each  IR and PC control.
- `aluOp`  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL.
- `accSel`  out  2  accumulator source: 0 ALU, 1 immediate, 2 switches, 3 memory.
- `accLoad`, `flagsLoad`, `outLoad`  out  1 each  register load strobes.
- `halted`  out  1  high in HALT.
- `state`  out  3  current state code, for debug.

## Operation
- States and codes: IDLE 0, FETCH 1, DECODE 2, EXECUTE 3, MEM 4, HALT 5, HOLD 6.
- All outputs are decoded combinationally from `state` and `opcode`. They are 0 in IDLE.
- IDLE: counts `IDLE_CYCLES`, then goes to FETCH.
- FETCH: `memRead`=1, `addrSel`=0.
  - While `memReady`=0, stay in FETCH.
  - When `memReady`=1: `irLoad`=1 and `pcInc`=1 in that cycle, then go to DECODE.
- DECODE: one cycle, no strobes. HLT goes to HALT. All other opcodes go to EXECUTE.
- EXECUTE, per opcode:
  - 0000 NOP: no strobes.
  - 0001 LDA, 0010 STA: no strobes; go to MEM.
  - 0011 ADD, 0100 SUB, 0101 AND, 0110 OR, 0111 XOR, 1110 SHL: matching `aluOp`, `accSel`=0, `accLoad`=1, `flagsLoad`=1.
  - 1000 LDI: `accSel`=1, `accLoad`=1.
  - 1001 JMP: `pcLoad`=1.
  - 1010 JZ: `pcLoad` = `zeroFlag`. 1011 JC: `pcLoad` = `carryFlag`.
  - 1100 IN: `accSel`=2, `accLoad`=1.
  - 1101 OUT: `outLoad`=1.
  - Every opcode except LDA/STA then returns to FETCH.
- MEM: `addrSel`=1.
  - LDA: `memRead`=1. On `memReady`, `accSel`=3 and `accLoad`=1.
  - STA: `memWrite`=1.
  - Hold until `memReady`=1, then go to FETCH.
- HALT: terminal; only `reset` exits.
- `memReady` is ignored unless `memRead` or `memWrite` is high.
- The request is held stable until ready; it is never withdrawn.

## Timing
- Reset value: state IDLE, all outputs 0, `halted`=0.
- Reset asserted mid-request drops `memRead`/`memWrite` immediately (asynchronous).
- Zero-wait memory (ready in the same cycle as the request) gives these minimum latencies:
  - ALU, LDI, IN, OUT, NOP, jumps: 3 cycles.
  - LDA/STA: 4 cycles.
- Each memory wait cycle adds exactly one cycle.
- Strobes are single-cycle. The datapath captures on the rising edge at the end of the strobe cycle.
- Flags written by instruction N are visible to a JZ/JC at N+1, because DECODE separates the two EXECUTE cycles.

## Configuration
- `AEOLUS_SINGLE_STEP_EN` defined:
  - Adds input `stepReq` (1 bit).
  - After every EXECUTE or MEM completion, go to HOLD instead of FETCH.
  - HOLD: all strobes 0; leave to FETCH on the first cycle with `stepReq`=1.
  - A `stepReq` already high when HOLD is entered counts.
  - Unused, `stepReq` is ignored.
- Undefined: no `stepReq` port, HOLD unreachable, behaviour exactly as above.

## Structure
- Shared package `aeolus_pkg`: opcode constants, `aluOp` encodings, `accSel` encodings, state encodings.
- Sub-module `aeolus_op_decode`: combinational opcode to class/strobe decode (ALU, load-imm, jump, memory, IO, halt). The FSM and handshake stay in `aeolus_sequencer`.

## Test plan
- Reset held 20 ns, then released, `memReady` tied 1 → `state` goes 0→1 after 1 cycle; all outputs 0 during reset.
- ADD (0011), `memReady`=1 → `irLoad`/`pcInc` at cycle 1; `aluOp`=000, `accLoad`=1, `flagsLoad`=1 at cycle 3; FETCH again at cycle 4.
- LDA (0001), `memReady` delayed 2 cycles in both FETCH and MEM → `memRead` held continuously; `accSel`=3 with `accLoad` only on the ready cycle; total 8 cycles.
- JZ (1010) with `zeroFlag`=0, then `zeroFlag`=1 → `pcLoad`=0 on the first, `pcLoad`=1 on the second.
- HLT (1111) → `halted`=1 from cycle 3, state 5 held for 100 cycles with all strobes 0; reset pulse returns to IDLE.
- With `AEOLUS_SINGLE_STEP_EN`: OUT (1101) → `outLoad` pulse, then state 6 held until a `stepReq` pulse, then FETCH on the next cycle.

Source files
------------

// File: rtl/aeolus_pkg.sv
// Shared definitions for the Aeolus control sequencer: state codes, opcodes,
// ALU operation and accumulator-source encodings, and the decoded opcode class.
package aeolus_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExecute = 3'd3,
    StMem     = 3'd4,
    StHalt    = 3'd5,
    StHold    = 3'd6
  } state_e;

  localparam logic [3:0] OpNop = 4'b0000;
  localparam logic [3:0] OpLda = 4'b0001;
  localparam logic [3:0] OpSta = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0011;
  localparam logic [3:0] OpSub = 4'b0100;
  localparam logic [3:0] OpAnd = 4'b0101;
  localparam logic [3:0] OpOr  = 4'b0110;
  localparam logic [3:0] OpXor = 4'b0111;
  localparam logic [3:0] OpLdi = 4'b1000;
  localparam logic [3:0] OpJmp = 4'b1001;
  localparam logic [3:0] OpJz  = 4'b1010;
  localparam logic [3:0] OpJc  = 4'b1011;
  localparam logic [3:0] OpIn  = 4'b1100;
  localparam logic [3:0] OpOut = 4'b1101;
  localparam logic [3:0] OpShl = 4'b1110;
  localparam logic [3:0] OpHlt = 4'b1111;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluXor = 3'b100,
    AluShl = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    AccAlu = 2'd0,
    AccImm = 2'd1,
    AccSw  = 2'd2,
    AccMem = 2'd3
  } acc_sel_e;

  // One-hot-ish instruction class flags plus the ALU operation for ALU opcodes.
  typedef struct packed {
    logic    is_alu;
    logic    is_ldi;
    logic    is_jmp;
    logic    is_jz;
    logic    is_jc;
    logic    is_lda;
    logic    is_sta;
    logic    is_in;
    logic    is_out;
    logic    is_halt;
    alu_op_e alu_op;
  } op_class_t;

endpackage

// File: rtl/aeolus_op_decode.sv
// Combinational opcode classifier for the Aeolus sequencer.
module aeolus_op_decode
  import aeolus_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_t  op_class
);

  // Map each opcode to its instruction class; NOP leaves every flag clear.
  always_comb begin
    op_class = '0;
    unique case (opcode)
      OpNop: ;
      OpLda: op_class.is_lda = 1'b1;
      OpSta: op_class.is_sta = 1'b1;
      OpAdd: begin op_class.is_alu = 1'b1; op_class.alu_op = AluAdd; end
      OpSub: begin op_class.is_alu = 1'b1; op_class.alu_op = AluSub; end
      OpAnd: begin op_class.is_alu = 1'b1; op_class.alu_op = AluAnd; end
      OpOr:  begin op_class.is_alu = 1'b1; op_class.alu_op = AluOr;  end
      OpXor: begin op_class.is_alu = 1'b1; op_class.alu_op = AluXor; end
      OpShl: begin op_class.is_alu = 1'b1; op_class.alu_op = AluShl; end
      OpLdi: op_class.is_ldi = 1'b1;
      OpJmp: op_class.is_jmp = 1'b1;
      OpJz:  op_class.is_jz  = 1'b1;
      OpJc:  op_class.is_jc  = 1'b1;
      OpIn:  op_class.is_in  = 1'b1;
      OpOut: op_class.is_out = 1'b1;
      OpHlt: op_class.is_halt = 1'b1;
    endcase
  end

endmodule

// File: rtl/aeolus_sequencer.sv
// Multi-cycle control sequencer for the Aeolus 8-bit CPU datapath.
// Steps IDLE -> FETCH -> DECODE -> EXECUTE [-> MEM] and decodes all datapath
// strobes from the current state and opcode.
// Optional feature: define AEOLUS_SINGLE_STEP_EN to add the stepReq input and
// the HOLD state entered after each completed instruction.
module aeolus_sequencer #(
  parameter int unsigned IDLE_CYCLES = 1
) (
  input  logic       boardCLK,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zeroFlag,
  input  logic       carryFlag,
  input  logic       memReady,
`ifdef AEOLUS_SINGLE_STEP_EN
  input  logic       stepReq,
`endif
  output logic       memRead,
  output logic       memWrite,
  output logic       addrSel,
  output logic       irLoad,
  output logic       pcInc,
  output logic       pcLoad,
  output logic [2:0] aluOp,
  output logic [1:0] accSel,
  output logic       accLoad,
  output logic       flagsLoad,
  output logic       outLoad,
  output logic       halted,
  output logic [2:0] state
);

  import aeolus_pkg::*;

  localparam logic [3:0] IdleLast = 4'(IDLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] idle_cnt_q, idle_cnt_d;
  op_class_t  op_class;
  logic       mem_done;
  state_e     done_state;

  aeolus_op_decode u_op_decode (
    .opcode   (opcode),
    .op_class (op_class)
  );

  // A request completes only while a strobe is actually asserted.
  assign mem_done = (memRead | memWrite) & memReady;

`ifdef AEOLUS_SINGLE_STEP_EN
  assign done_state = StHold;
`else
  assign done_state = StFetch;
`endif

  // State and idle-counter registers; reset forces IDLE asynchronously.
  always_ff @(posedge boardCLK or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      idle_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = 4'd0;
    unique case (state_q)
      StIdle: begin
        if (idle_cnt_q >= IdleLast) begin
          state_d = StFetch;
        end else begin
          idle_cnt_d = idle_cnt_q + 4'd1;
        end
      end
      StFetch: begin
        if (mem_done) state_d = StDecode;
      end
      StDecode: begin
        state_d = op_class.is_halt ? StHalt : StExecute;
      end
      StExecute: begin
        state_d = (op_class.is_lda || op_class.is_sta) ? StMem : done_state;
      end
      StMem: begin
        if (mem_done) state_d = done_state;
      end
      StHalt: state_d = StHalt;
      StHold: begin
`ifdef AEOLUS_SINGLE_STEP_EN
        if (stepReq) state_d = StFetch;
`else
        state_d = StFetch;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobe decode from state and opcode; everything defaults low.
  always_comb begin
    memRead   = 1'b0;
    memWrite  = 1'b0;
    addrSel   = 1'b0;
    irLoad    = 1'b0;
    pcInc     = 1'b0;
    pcLoad    = 1'b0;
    aluOp     = AluAdd;
    accSel    = AccAlu;
    accLoad   = 1'b0;
    flagsLoad = 1'b0;
    outLoad   = 1'b0;
    halted    = 1'b0;
    unique case (state_q)
      StFetch: begin
        memRead = 1'b1;
        if (memReady) begin
          irLoad = 1'b1;
          pcInc  = 1'b1;
        end
      end
      StExecute: begin
        if (op_class.is_alu) begin
          aluOp     = op_class.alu_op;
          accSel    = AccAlu;
          accLoad   = 1'b1;
          flagsLoad = 1'b1;
        end
        if (op_class.is_ldi) begin
          accSel  = AccImm;
          accLoad = 1'b1;
        end
        if (op_class.is_in) begin
          accSel  = AccSw;
          accLoad = 1'b1;
        end
        if (op_class.is_out) outLoad = 1'b1;
        pcLoad = op_class.is_jmp | (op_class.is_jz & zeroFlag) | (op_class.is_jc & carryFlag);
      end
      StMem: begin
        addrSel = 1'b1;
        if (op_class.is_lda) begin
          memRead = 1'b1;
          if (memReady) begin
            accSel  = AccMem;
            accLoad = 1'b1;
          end
        end else if (op_class.is_sta) begin
          memWrite = 1'b1;
        end
      end
      StHalt: halted = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_aeolus_sequencer.sv
// Directed, table-driven bench for aeolus_sequencer.
module tb_aeolus_sequencer;

  logic       boardCLK = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       zeroFlag = 1'b0;
  logic       carryFlag = 1'b0;
  logic       memReady = 1'b1;
  logic       stepReq = 1'b1;
  logic       memRead, memWrite, addrSel, irLoad, pcInc, pcLoad;
  logic [2:0] aluOp;
  logic [1:0] accSel;
  logic       accLoad, flagsLoad, outLoad, halted;
  logic [2:0] state;

  aeolus_sequencer #(.IDLE_CYCLES(1)) dut (
    .boardCLK  (boardCLK),
    .reset     (reset),
    .opcode    (opcode),
    .zeroFlag  (zeroFlag),
    .carryFlag (carryFlag),
    .memReady  (memReady),
`ifdef AEOLUS_SINGLE_STEP_EN
    .stepReq   (stepReq),
`endif
    .memRead   (memRead),
    .memWrite  (memWrite),
    .addrSel   (addrSel),
    .irLoad    (irLoad),
    .pcInc     (pcInc),
    .pcLoad    (pcLoad),
    .aluOp     (aluOp),
    .accSel    (accSel),
    .accLoad   (accLoad),
    .flagsLoad (flagsLoad),
    .outLoad   (outLoad),
    .halted    (halted),
    .state     (state)
  );

  always #5 boardCLK = ~boardCLK;

  // Observed outputs packed as
  // {memRead,memWrite,addrSel,irLoad,pcInc,pcLoad,aluOp,accSel,accLoad,flagsLoad,outLoad,halted,state}
  logic [17:0] obs;
  assign obs = {memRead, memWrite, addrSel, irLoad, pcInc, pcLoad, aluOp, accSel,
                accLoad, flagsLoad, outLoad, halted, state};

  localparam logic [17:0] MR   = 18'h20000;
  localparam logic [17:0] MW   = 18'h10000;
  localparam logic [17:0] AS   = 18'h08000;
  localparam logic [17:0] IRL  = 18'h04000;
  localparam logic [17:0] PCI  = 18'h02000;
  localparam logic [17:0] PCL  = 18'h01000;
  localparam logic [17:0] ACCL = 18'h00040;
  localparam logic [17:0] FL   = 18'h00020;
  localparam logic [17:0] OL   = 18'h00010;
  localparam logic [17:0] HLT  = 18'h00008;

  function automatic logic [17:0] alu(input int n);
    return 18'(n) << 9;
  endfunction

  function automatic logic [17:0] acc(input int n);
    return 18'(n) << 7;
  endfunction

  function automatic logic [17:0] st(input int n);
    return 18'(n);
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic        z;
    logic        c;
    logic        rdy;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [17:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%05h exp=%05h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic z, input logic c, input logic rdy,
                     input logic [17:0] exp);
    vec_t v;
    v.op = op; v.z = z; v.c = c; v.rdy = rdy; v.exp = exp;
    tbl.push_back(v);
  endtask

  // After each completed instruction single-step builds pass through HOLD once
  // (stepReq is held high during the table).
  task automatic done_row();
`ifdef AEOLUS_SINGLE_STEP_EN
    add(4'h0, 1'b0, 1'b0, 1'b1, st(6));
`endif
  endtask

  // Zero-wait FETCH, DECODE, EXECUTE for a non-memory instruction.
  task automatic instr(input logic [3:0] op, input logic z, input logic c,
                       input logic [17:0] exec_exp);
    add(op, 1'b0, 1'b0, 1'b1, MR | IRL | PCI | st(1));
    add(op, 1'b0, 1'b0, 1'b0, st(2));
    add(op, z, c, 1'b0, exec_exp);
    done_row();
  endtask

  initial begin
    // Reset held 20 ns: all outputs zero.
    #2;
    check("reset_outputs", 18'h0);
    @(negedge boardCLK);
    @(negedge boardCLK);
    reset = 1'b0;

    add(4'h3, 1'b0, 1'b0, 1'b1, st(0));                       // IDLE
    instr(4'h3, 1'b0, 1'b0, alu(0) | ACCL | FL | st(3));      // ADD
    // LDA with two wait cycles in FETCH and MEM
    add(4'h1, 1'b0, 1'b0, 1'b0, MR | st(1));
    add(4'h1, 1'b0, 1'b0, 1'b0, MR | st(1));
    add(4'h1, 1'b0, 1'b0, 1'b1, MR | IRL | PCI | st(1));
    add(4'h1, 1'b0, 1'b0, 1'b1, st(2));
    add(4'h1, 1'b0, 1'b0, 1'b1, st(3));
    add(4'h1, 1'b0, 1'b0, 1'b0, MR | AS | st(4));
    add(4'h1, 1'b0, 1'b0, 1'b0, MR | AS | st(4));
    add(4'h1, 1'b0, 1'b0, 1'b1, MR | AS | acc(3) | ACCL | st(4));
    done_row();
    // STA zero-wait
    add(4'h2, 1'b0, 1'b0, 1'b1, MR | IRL | PCI | st(1));
    add(4'h2, 1'b0, 1'b0, 1'b1, st(2));
    add(4'h2, 1'b0, 1'b0, 1'b1, st(3));
    add(4'h2, 1'b0, 1'b0, 1'b1, MW | AS | st(4));
    done_row();
    instr(4'hA, 1'b0, 1'b1, st(3));                            // JZ not taken
    instr(4'hA, 1'b1, 1'b0, PCL | st(3));                      // JZ taken
    instr(4'hB, 1'b0, 1'b0, st(3));                            // JC not taken
    instr(4'hB, 1'b0, 1'b1, PCL | st(3));                      // JC taken
    instr(4'h4, 1'b0, 1'b0, alu(1) | ACCL | FL | st(3));      // SUB
    instr(4'h5, 1'b0, 1'b0, alu(2) | ACCL | FL | st(3));      // AND
    instr(4'h6, 1'b0, 1'b0, alu(3) | ACCL | FL | st(3));      // OR
    instr(4'h7, 1'b0, 1'b0, alu(4) | ACCL | FL | st(3));      // XOR
    instr(4'hE, 1'b0, 1'b0, alu(5) | ACCL | FL | st(3));      // SHL
    instr(4'h8, 1'b0, 1'b0, acc(1) | ACCL | st(3));           // LDI
    instr(4'h9, 1'b1, 1'b1, PCL | st(3));                      // JMP
    instr(4'hC, 1'b0, 1'b0, acc(2) | ACCL | st(3));           // IN
    instr(4'hD, 1'b0, 1'b0, OL | st(3));                       // OUT
    instr(4'h0, 1'b1, 1'b1, st(3));                            // NOP
    // HLT
    add(4'hF, 1'b0, 1'b0, 1'b1, MR | IRL | PCI | st(1));
    add(4'hF, 1'b0, 1'b0, 1'b1, st(2));
    add(4'hF, 1'b0, 1'b0, 1'b1, HLT | st(5));

    for (int i = 0; i < tbl.size(); i++) begin
      opcode    = tbl[i].op;
      zeroFlag  = tbl[i].z;
      carryFlag = tbl[i].c;
      memReady  = tbl[i].rdy;
      #1;
      check($sformatf("vec%0d", i), tbl[i].exp);
      @(negedge boardCLK);
    end

    // HALT is terminal regardless of inputs.
    for (int i = 0; i < 100; i++) begin
      opcode    = 4'($urandom_range(0, 15));
      zeroFlag  = 1'($urandom_range(0, 1));
      carryFlag = 1'($urandom_range(0, 1));
      memReady  = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("halt_hold%0d", i), HLT | st(5));
      @(negedge boardCLK);
    end

    // Asynchronous reset from HALT.
    #2 reset = 1'b1;
    #1 check("halt_async_reset", 18'h0);
    @(negedge boardCLK);
    reset = 1'b0;
    memReady = 1'b0;
    opcode = 4'h3;
    #1 check("idle_after_reset", st(0));
    @(negedge boardCLK);
    #1 check("fetch_wait", MR | st(1));
    // Reset mid-request drops the strobe before any clock edge.
    #1 reset = 1'b1;
    #1 check("reset_drops_memread", 18'h0);
    @(negedge boardCLK);
    reset = 1'b0;
    #1 check("idle_again", st(0));
    @(negedge boardCLK);

`ifdef AEOLUS_SINGLE_STEP_EN
    // OUT, then HOLD until a stepReq pulse.
    stepReq = 1'b0;
    memReady = 1'b1;
    opcode = 4'hD;
    #1 check("ss_fetch", MR | IRL | PCI | st(1));
    @(negedge boardCLK);
    #1 check("ss_decode", st(2));
    @(negedge boardCLK);
    #1 check("ss_out", OL | st(3));
    @(negedge boardCLK);
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("ss_hold%0d", i), st(6));
      @(negedge boardCLK);
    end
    stepReq = 1'b1;
    #1 check("ss_hold_step", st(6));
    @(negedge boardCLK);
    stepReq = 1'b0;
    memReady = 1'b0;
    #1 check("ss_fetch_after_step", MR | st(1));
    @(negedge boardCLK);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
